// File: rtl/fb_arbiter_if.sv
// Frame-buffer arbiter bus: camera write port, analyzer/display read ports,
// freeze/frame_done control and the single-port RAM side.
interface fb_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 3
);
  logic          cam_we;
  logic [AW-1:0] cam_addr;
  logic [DW-1:0] cam_data;

  logic          ana_req;
  logic [AW-1:0] ana_addr;
  logic          ana_gnt;
  logic          ana_rvalid;
  logic [DW-1:0] ana_rdata;

  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_gnt;
  logic          vid_rvalid;
  logic [DW-1:0] vid_rdata;

  logic          freeze;
  logic          frame_done;

  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  // arbiter side
  modport slave (
    input  cam_we, cam_addr, cam_data,
    input  ana_req, ana_addr, vid_req, vid_addr, freeze, ram_rdata,
    output ana_gnt, ana_rvalid, ana_rdata,
    output vid_gnt, vid_rvalid, vid_rdata,
    output frame_done, ram_we, ram_addr, ram_wdata
  );

  // clients and RAM side
  modport master (
    output cam_we, cam_addr, cam_data,
    output ana_req, ana_addr, vid_req, vid_addr, freeze, ram_rdata,
    input  ana_gnt, ana_rvalid, ana_rdata,
    input  vid_gnt, vid_rvalid, vid_rdata,
    input  frame_done, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/fb_arbiter.sv
// Single-port frame-buffer arbiter: camera writes win, analyzer/display reads
// round-robin, FILL/FROZEN/SYNC write control. FB_ARBITER_DROP_STATS_EN adds drop_cnt.
module fb_arbiter #(
  parameter int AW         = 15,
  parameter int DW         = 3,
  parameter int FRAME_LAST = 25343
) (
  input  logic          clk,
  input  logic          rst,
  fb_arbiter_if.slave   bus
`ifdef FB_ARBITER_DROP_STATS_EN
  ,
  output logic [15:0]   drop_cnt
`endif
);

  localparam logic [AW-1:0] LAST_A = AW'(FRAME_LAST);

  typedef enum logic [1:0] {FILL, FROZEN, SYNC} state_t;

  state_t        state;
  logic          ptr;          // 0: analyzer has priority, 1: display
  logic          rd_ana_q, rd_vid_q;
  logic          ram_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;
  logic          ana_rvalid_q, vid_rvalid_q;
  logic [DW-1:0] ana_rdata_q, vid_rdata_q;
  logic          frame_done_q;

  logic in_range, cam_ok, ana_gnt, vid_gnt, at_last;

  // Grants are gated by rst so they clear asynchronously with the registers.
  always_comb begin
    in_range = bus.cam_addr <= LAST_A;
    at_last  = bus.cam_addr == LAST_A;
    cam_ok   = rst && bus.cam_we && in_range &&
               ((state == FILL) || ((state == SYNC) && (bus.cam_addr == '0)));
    ana_gnt  = rst && !cam_ok && bus.ana_req && (!bus.vid_req || !ptr);
    vid_gnt  = rst && !cam_ok && bus.vid_req && (!bus.ana_req ||  ptr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FILL;
      ptr          <= 1'b0;
      rd_ana_q     <= 1'b0;
      rd_vid_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ana_rvalid_q <= 1'b0;
      vid_rvalid_q <= 1'b0;
      ana_rdata_q  <= '0;
      vid_rdata_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ram_we_q <= cam_ok;
      if (cam_ok) begin
        ram_addr_q  <= bus.cam_addr;
        ram_wdata_q <= bus.cam_data;
      end else if (ana_gnt) begin
        ram_addr_q  <= bus.ana_addr;
      end else if (vid_gnt) begin
        ram_addr_q  <= bus.vid_addr;
      end

      if (ana_gnt || vid_gnt) ptr <= ana_gnt;

      rd_ana_q     <= ana_gnt;
      rd_vid_q     <= vid_gnt;
      ana_rvalid_q <= rd_ana_q;
      vid_rvalid_q <= rd_vid_q;
      if (rd_ana_q) ana_rdata_q <= bus.ram_rdata;
      if (rd_vid_q) vid_rdata_q <= bus.ram_rdata;

      frame_done_q <= cam_ok && at_last;

      case (state)
        FILL:    if (cam_ok && at_last && bus.freeze) state <= FROZEN;
        FROZEN:  if (!bus.freeze) state <= SYNC;
        SYNC:    if (cam_ok) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

`ifdef FB_ARBITER_DROP_STATS_EN
  logic        cam_drop;
  logic [15:0] drop_cnt_q;

  assign cam_drop = bus.cam_we && !cam_ok && (state != FILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if ((state == SYNC) && cam_ok) begin
      drop_cnt_q <= '0;
    end else if (cam_drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign bus.ana_gnt    = ana_gnt;
  assign bus.vid_gnt    = vid_gnt;
  assign bus.ana_rvalid = ana_rvalid_q;
  assign bus.vid_rvalid = vid_rvalid_q;
  assign bus.ana_rdata  = ana_rdata_q;
  assign bus.vid_rdata  = vid_rdata_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ram_we     = ram_we_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter; the RAM model returns mem[ram_addr] in the
// cycle the registered address is presented, giving rvalid two cycles after grant.
module tb_fb_arbiter;
  localparam int AW = 15;
  localparam int DW = 3;
  localparam int FRAME_LAST = 25343;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef FB_ARBITER_DROP_STATS_EN
  logic [15:0] drop_cnt;
`endif

  fb_arbiter #(.AW(AW), .DW(DW), .FRAME_LAST(FRAME_LAST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FB_ARBITER_DROP_STATS_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] model [0:(1<<AW)-1];
  logic          pl_we;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    else if (pl_we) mem[pl_addr] <= pl_data;
  end
  assign bus.ram_rdata = mem[bus.ram_addr];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] aq[$];
  logic [DW-1:0] vq[$];
  int            fd_pending = 0;
  wr_t           w;
  logic [DW-1:0] exp_d;
  logic [DW-1:0] ana_last, vid_last;

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk) begin
    if (!rst) begin
      ana_last = '0;
      vid_last = '0;
    end else begin
      if (bus.ram_we) begin
        chk("ram_we expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("ram_addr", 32'(bus.ram_addr), 32'(w.a));
          chk("ram_wdata", 32'(bus.ram_wdata), 32'(w.d));
        end
      end
      if (bus.ana_rvalid) begin
        chk("ana_rvalid expected", 32'(aq.size() > 0), 32'd1);
        chk("vid_rdata held", 32'(bus.vid_rdata), 32'(vid_last));
        if (aq.size() > 0) begin
          exp_d = aq.pop_front();
          chk("ana_rdata", 32'(bus.ana_rdata), 32'(exp_d));
        end
        ana_last = bus.ana_rdata;
      end
      if (bus.vid_rvalid) begin
        chk("vid_rvalid expected", 32'(vq.size() > 0), 32'd1);
        chk("ana_rdata held", 32'(bus.ana_rdata), 32'(ana_last));
        if (vq.size() > 0) begin
          exp_d = vq.pop_front();
          chk("vid_rdata", 32'(bus.vid_rdata), 32'(exp_d));
        end
        vid_last = bus.vid_rdata;
      end
      if (bus.frame_done) begin
        chk("frame_done expected", 32'(fd_pending > 0), 32'd1);
        if (fd_pending > 0) fd_pending--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pl(input int a, input logic [DW-1:0] d);
    pl_we = 1'b1; pl_addr = AW'(a); pl_data = d;
    model[a] = d;
    step();
    pl_we = 1'b0;
  endtask

  task automatic cam_wr(input int a, input logic [DW-1:0] d, input bit accept);
    bus.cam_we = 1'b1; bus.cam_addr = AW'(a); bus.cam_data = d;
    if (accept) begin
      wq.push_back('{a: AW'(a), d: d});
      model[a] = d;
      if (a == FRAME_LAST) fd_pending++;
    end
    step();
    bus.cam_we = 1'b0;
  endtask

  bit rr_ana [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.cam_we = 1'b0; bus.cam_addr = '0; bus.cam_data = '0;
    bus.ana_req = 1'b0; bus.ana_addr = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.freeze = 1'b0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    #2;
    chk("rst ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst ana_rvalid", 32'(bus.ana_rvalid), 32'd0);
    chk("rst frame_done", 32'(bus.frame_done), 32'd0);
    step(); step();
    rst = 1'b1;
    pl(10, 3'd3); pl(20, 3'd6); pl(100, 3'd5);

    // Round-robin with both requests held
    bus.ana_addr = 15'd10; bus.vid_addr = 15'd20;
    bus.ana_req = 1'b1; bus.vid_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr ana_gnt", 32'(bus.ana_gnt), 32'(rr_ana[i]));
      chk("rr vid_gnt", 32'(bus.vid_gnt), 32'(!rr_ana[i]));
      if (rr_ana[i]) aq.push_back(3'd3); else vq.push_back(3'd6);
      step();
    end

    // Camera write collides with both reads
    bus.cam_we = 1'b1; bus.cam_addr = 15'd7; bus.cam_data = 3'd2;
    wq.push_back('{a: 15'd7, d: 3'd2}); model[7] = 3'd2;
    #1;
    chk("coll ana_gnt", 32'(bus.ana_gnt), 32'd0);
    chk("coll vid_gnt", 32'(bus.vid_gnt), 32'd0);
    step();
    bus.cam_we = 1'b0;
    #1;
    chk("coll ram_we", 32'(bus.ram_we), 32'd1);
    chk("coll ana_gnt next", 32'(bus.ana_gnt), 32'd1);
    chk("coll vid_gnt next", 32'(bus.vid_gnt), 32'd0);
    aq.push_back(3'd3);
    step();
    bus.ana_req = 1'b0;
    #1;
    chk("coll vid_gnt last", 32'(bus.vid_gnt), 32'd1);
    vq.push_back(3'd6);
    step();
    bus.vid_req = 1'b0;

    // Single analyzer read: gnt N, ram_addr N+1, rvalid N+2
    bus.ana_req = 1'b1; bus.ana_addr = 15'd100;
    #1;
    chk("single ana_gnt", 32'(bus.ana_gnt), 32'd1);
    aq.push_back(3'd5);
    step();
    bus.ana_req = 1'b0;
    #1;
    chk("single ram_addr", 32'(bus.ram_addr), 32'd100);
    chk("single ram_we", 32'(bus.ram_we), 32'd0);
    chk("single rvalid N+1", 32'(bus.ana_rvalid), 32'd0);
    step();
    chk("single rvalid N+2", 32'(bus.ana_rvalid), 32'd1);
    bus.vid_req = 1'b1; bus.vid_addr = 15'd7;
    #1;
    chk("readback vid_gnt", 32'(bus.vid_gnt), 32'd1);
    vq.push_back(3'd2);
    step();
    bus.vid_req = 1'b0;

    // Out-of-range camera address
    cam_wr(FRAME_LAST + 1, 3'd1, 1'b0);
    chk("oor ram_we", 32'(bus.ram_we), 32'd0);
    step();
    chk("oor frame_done", 32'(bus.frame_done), 32'd0);

    // Frame end without freeze, then mid-frame freeze is ignored
    cam_wr(FRAME_LAST, 3'd1, 1'b1);
    chk("fd pulse 1", 32'(bus.frame_done), 32'd1);
    bus.freeze = 1'b1;
    cam_wr(300, 3'd2, 1'b1);
    bus.freeze = 1'b0;
    cam_wr(301, 3'd3, 1'b1);

    // Freeze at frame end, drops in FROZEN, reads still served
    bus.freeze = 1'b1;
    cam_wr(FRAME_LAST, 3'd4, 1'b1);
    chk("fd pulse 2", 32'(bus.frame_done), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.cam_we = 1'b1; bus.cam_addr = AW'(i); bus.cam_data = 3'd7;
      if (i == 5) begin
        bus.ana_req = 1'b1; bus.ana_addr = AW'(FRAME_LAST);
        aq.push_back(3'd4);
      end
      #1;
      if (i == 5) chk("frozen ana_gnt", 32'(bus.ana_gnt), 32'd1);
      step();
      bus.cam_we = 1'b0; bus.ana_req = 1'b0;
    end
`ifdef FB_ARBITER_DROP_STATS_EN
    chk("drop_cnt frozen", 32'(drop_cnt), 32'd10);
`endif
    bus.freeze = 1'b0;
    step();
    cam_wr(500, 3'd1, 1'b0);
    cam_wr(501, 3'd1, 1'b0);
    cam_wr(502, 3'd1, 1'b0);
`ifdef FB_ARBITER_DROP_STATS_EN
    chk("drop_cnt sync", 32'(drop_cnt), 32'd13);
`endif
    cam_wr(0, 3'd3, 1'b1);
`ifdef FB_ARBITER_DROP_STATS_EN
    chk("drop_cnt cleared", 32'(drop_cnt), 32'd0);
`endif
    cam_wr(1, 3'd5, 1'b1);

    // Reset one cycle after a read grant
    bus.ana_req = 1'b1; bus.ana_addr = 15'd10;
    #1;
    chk("pre-rst ana_gnt", 32'(bus.ana_gnt), 32'd1);
    step();
    bus.ana_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("async ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("async ana_rdata", 32'(bus.ana_rdata), 32'd0);
    chk("async vid_rdata", 32'(bus.vid_rdata), 32'd0);
    chk("async ana_rvalid", 32'(bus.ana_rvalid), 32'd0);
    step(); step();
    rst = 1'b1;
    step(); step(); step();

    // Pointer back to analyzer, state back to FILL
    bus.ana_req = 1'b1; bus.vid_req = 1'b1;
    bus.ana_addr = 15'd10; bus.vid_addr = 15'd20;
    #1;
    chk("post-rst ana_gnt", 32'(bus.ana_gnt), 32'd1);
    chk("post-rst vid_gnt", 32'(bus.vid_gnt), 32'd0);
    aq.push_back(3'd3);
    step();
    bus.ana_req = 1'b0;
    #1;
    chk("post-rst vid_gnt 2", 32'(bus.vid_gnt), 32'd1);
    vq.push_back(3'd6);
    step();
    bus.vid_req = 1'b0;
    cam_wr(5, 3'd6, 1'b1);
    step(); step(); step(); step();

    chk("writes drained", 32'(wq.size()), 32'd0);
    chk("ana reads drained", 32'(aq.size()), 32'd0);
    chk("vid reads drained", 32'(vq.size()), 32'd0);
    chk("frame_done drained", 32'(fd_pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 15, frame-buffer address width.
REQ-002 SHALL have parameter DW, default 3, pixel width (RGB111).
REQ-003 SHALL have parameter FRAME_LAST, default 25343, last pixel address of a 176x144 frame.
REQ-004 SHALL have port clk  in  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cam_we in 1, cam_addr in AW, cam_data in DW: camera write strobe, address and pixel; the camera never stalls.
REQ-007 SHALL have ports ana_req in 1, ana_addr in AW, ana_gnt out 1, ana_rvalid out 1, ana_rdata out DW: analyzer read port.
REQ-008 SHALL have ports vid_req in 1, vid_addr in AW, vid_gnt out 1, vid_rvalid out 1, vid_rdata out DW: display read port.
REQ-009 SHALL have port freeze  in  1  analyzer request to hold the current frame.
REQ-010 SHALL have port frame_done  out  1  one-cycle pulse when FRAME_LAST is written.
REQ-011 SHALL have ports ram_we out 1, ram_addr out AW, ram_wdata out DW, ram_rdata in DW: single-port RAM with 1-cycle read latency.

Function
REQ-012 SHALL grant exactly one RAM access per cycle: an accepted camera write beats all reads.
REQ-013 SHALL arbitrate between ana_req and vid_req round-robin; the pointer moves to the other port only on a read grant; after reset the analyzer has priority.
REQ-014 SHALL drive ana_gnt/vid_gnt combinationally in the cycle the request is accepted; the requester holds req and addr stable until gnt.
REQ-015 SHALL register ram_we/ram_addr/ram_wdata: the access granted in cycle N appears on the RAM in cycle N+1.
REQ-016 SHALL register ram_rdata into the granted port's rdata and assert that port's rvalid for one cycle in N+2; the other port's rdata is held.
REQ-017 SHALL run write-control FSM states FILL, FROZEN, SYNC.
REQ-018 FILL: camera writes pass; a write to FRAME_LAST pulses frame_done next cycle and enters FROZEN if freeze=1 in that cycle, else stays in FILL.
REQ-019 FROZEN: camera writes are dropped (no ram_we) and do not block reads; freeze=0 -> SYNC.
REQ-020 SYNC: camera writes are dropped until a write with cam_addr=0, which is accepted and enters FILL, so no partial frame is ever stored.
REQ-021 SHALL not re-enter FROZEN from a freeze asserted mid-frame; freeze only takes effect at FRAME_LAST.
REQ-022 SHALL ignore cam_addr > FRAME_LAST (no write, no frame_done).
REQ-023 SHALL, when camera write and both reads coincide, issue the write and keep both reads pending without moving the round-robin pointer.

Reset
REQ-024 SHALL on rst=0 immediately clear ram_we, ram_addr, ram_wdata, all gnt, rvalid, rdata, frame_done, the pointer, and set state FILL.
REQ-025 SHALL discard in-flight reads on reset; no rvalid follows reset release for pre-reset grants.

Configuration
REQ-026 SHALL, with macro FB_ARBITER_DROP_STATS_EN defined, add output drop_cnt (16 bits, reset 0) counting camera writes dropped in FROZEN/SYNC, saturating at 65535 and clearing on each entry to FILL.
REQ-027 SHALL, without FB_ARBITER_DROP_STATS_EN, have no drop_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-028 Single analyzer read of addr 100 holding 3'b101, no contention -> ana_gnt in cycle N, ram_addr=100 in N+1, ana_rvalid=1 with ana_rdata=3'b101 in N+2.
REQ-029 ana_req and vid_req held together for 4 cycles, no camera -> grants alternate ana,vid,ana,vid.
REQ-030 cam_we plus both reads in the same cycle -> ram_we=1 next cycle, no gnt that cycle, reads granted in the following two cycles.
REQ-031 freeze=1 at cam write to 25343 -> frame_done pulse, FROZEN; 10 further writes dropped (drop_cnt=10 with macro); freeze=0 then writes to 500..502 dropped, write to 0 accepted.
REQ-032 rst=0 one cycle after a read grant -> outputs clear asynchronously, no rvalid after release, state FILL.
REQ-033 cam write to addr 25344 -> no ram_we, no frame_done.
